sipo_deser: RTL and testbench
=============================

# sipo_deser

Multi-lane, framed serial-in parallel-out deserialiser. It is the parametrised successor to the single-lane SIPO shift register. It captures `LANES` serial pins in parallel and counts `WIDTH` bits per word, with a selectable bit order. Completed words go to a holding register and are presented on a valid/ready handshake toward the consuming IP core, with resync and overrun reporting.

## Interface
- `WIDTH`, 32: bits per word per lane; must be ≥1.
- `LANES`, 1: number of serial input lanes; must be ≥1.
- `MSB_FIRST`, 1: 1 = first received bit lands in word bit `WIDTH-1`; 0 = first received bit lands in bit 0.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: shift enable; samples `data_in` on this edge.
- `sync` in 1: frame restart; discards the partial word.
- `data_in` in `LANES`: one serial bit per lane.
- `data_out` out `LANES*WIDTH`: holding register; lane i occupies `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1: holding register contains an unconsumed word.
- `out_ready` in 1: consumer accepts the word when `out_valid && out_ready`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `bit_cnt` out `max(1,clog2(WIDTH))`: bits received in the current partial word.

## Operation
- Reset (async assert, sync release): shift registers = 0, `bit_cnt` = 0, `data_out` = 0, `out_valid` = 0, `overrun` = 0.
- Shift: on `load`, each lane shifts in `data_in[i]`.
  - `MSB_FIRST=1`: `{sr[WIDTH-2:0], bit}`.
  - `MSB_FIRST=0`: `{bit, sr[WIDTH-1:1]}`.
- Counter: advances only on `load`.
  - Wraps to 0 after `WIDTH-1`.
  - A cycle with `load` and `bit_cnt==WIDTH-1` is a "completion".
- Completion writes the assembled word (the shift contents including this cycle's bit) into `data_out` and sets `out_valid`. This happens if the holding register is free, meaning `!out_valid`, or the word is consumed in the same cycle (`out_valid && out_ready`).
- If the holding register is not free at completion:
  - the word is dropped and `overrun` pulses high for 1 cycle;
  - `data_out` and `out_valid` are unchanged;
  - the counter still wraps to 0.
- Consume without completion: `out_valid && out_ready` clears `out_valid`. `data_out` retains its last value.
- `sync`: forces the counter to 0 for the next word.
  - `sync` with `load`: this cycle's bit is bit 0 of the new word, and `bit_cnt` becomes 1.
  - `sync` has priority over completion, so no word is emitted on that cycle.
- `WIDTH==1`: every `load` is a completion. `bit_cnt` stays 0.
- Idle (`load`=0): all state holds. `out_valid` clears only via consumption.
- Synthesis: shift-register inference is disabled (vendor attributes), as for the existing SIPO.

## Timing
- Latency: the word is visible on `data_out` with `out_valid`=1 in the cycle after the clock edge that sampled its last bit.
- Sustained throughput: one word per `WIDTH` loads, provided `out_ready` is high at completion.
- `overrun` is registered and asserts the cycle after the dropping edge.
- `out_valid` stays high until consumed. `data_out` is stable while `out_valid`=1.
- Reset mid-word or mid-handshake:
  - the word is lost and `out_valid` drops immediately (async);
  - after release, counting restarts at bit 0.

## Structure
- Shared package `shift_reg_pkg` holds:
  - `clog2`/counter-width function;
  - bit-order constants `ORDER_MSB_FIRST`=1, `ORDER_LSB_FIRST`=0, reused by the SIPO/PISO family.
- Sub-module `sipo_lane`: one `WIDTH`-bit shift register with a `MSB_FIRST` parameter, async reset and `load`. It is instantiated `LANES` times in a generate loop.
- The top level holds the shared bit counter, completion/sync logic, the holding register and the handshake.

## Test plan
All cases use `WIDTH`=8 and `LANES`=2.
- **Reset:** assert `rst` mid-stream after 5 loads → `out_valid`=0, `data_out`=0, `bit_cnt`=0, `overrun`=0 asynchronously. After release, a full word of 8 fresh bits is needed.
- **Basic, `MSB_FIRST`=1:**
  - stimulus: `load` every cycle, `out_ready`=1; lane0 bits 1,0,1,0,0,1,1,0 and lane1 bits 0,0,1,1,1,1,0,0;
  - response: `out_valid`=1 for one cycle starting the cycle after the 8th load, with `data_out`=16'h3CA6.
- **Bit order, `MSB_FIRST`=0:** same stimulus → `data_out`=16'h3C65.
- **Back-pressure:**
  - stimulus: `out_ready`=0, 16 consecutive loads;
  - response: first word held with `out_valid`=1; `overrun` pulses once after the 16th load; `data_out` still holds word 1;
  - then raise `out_ready` → `out_valid` drops next cycle.
- **Simultaneous consume and complete:** `out_ready`=1 exactly on the completion edge of word 2 → word 2 replaces word 1, `out_valid` stays 1, no `overrun`.
- **Sync and gaps:**
  - stimulus: 3 loads, then `sync` with `load`, then 7 loads with `load` low every other cycle;
  - response: exactly one word is emitted, made of the sync-cycle bit followed by the 7 later bits; `bit_cnt` holds during the gaps.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared constants and helpers for the SIPO/PISO shift-register family
package shift_reg_pkg;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // Width of a counter that indexes n bits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sipo_lane.sv
// rtl/sipo_lane.sv - one WIDTH-bit serial-in shift register with selectable bit order
module sipo_lane
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             data_in,
    output logic [WIDTH-1:0] shift_next
);

    (* shreg_extract = "no", srl_style = "register" *) logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign shifted = data_in;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted = {sr[WIDTH-2:0], data_in};
        end else begin : g_lsb
            assign shifted = {data_in, sr[WIDTH-1:1]};
        end
    endgenerate

    // The top level captures this value on completion so the word includes the current bit.
    assign shift_next = load ? shifted : sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= shift_next;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - multi-lane framed deserialiser with holding register and valid/ready output
module sipo_deser
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic                               sync,
    input  logic [LANES-1:0]                   data_in,
    output logic [LANES*WIDTH-1:0]             data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overrun,
    output logic [cnt_width(WIDTH)-1:0]        bit_cnt
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [LANES*WIDTH-1:0] word_next;
    logic                   complete;
    logic                   consume;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sipo_lane #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .data_in    (data_in[i]),
                .shift_next (word_next[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // sync outranks completion: a word is never emitted on a resync edge.
    assign complete = load && !sync && (bit_cnt == LAST);
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (sync) begin
            bit_cnt <= (load && WIDTH > 1) ? CW'(1) : '0;
        end else if (load) begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    data_out  <= word_next;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - randomized bench for sipo_deser against a word-level reference model
module tb_sipo_deser;

    localparam int W = 8;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic           sync = 1'b0;
    logic           out_ready = 1'b0;
    logic [L-1:0]   data_in = '0;

    logic [L*W-1:0] dout_m, dout_l;
    logic           v_m, v_l, o_m, o_l;
    logic [2:0]     bc_m, bc_l;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .sync(sync), .data_in(data_in),
        .data_out(dout_m), .out_valid(v_m), .out_ready(out_ready),
        .overrun(o_m), .bit_cnt(bc_m)
    );

    sipo_deser #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .sync(sync), .data_in(data_in),
        .data_out(dout_l), .out_valid(v_l), .out_ready(out_ready),
        .overrun(o_l), .bit_cnt(bc_l)
    );

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    // Reference model: bits are collected in arrival order, words assembled only on the W-th bit.
    bit [W-1:0]   rx [L];
    int           mcnt;
    bit           mvalid, movr;
    bit [L*W-1:0] mword_m, mword_l;

    localparam logic [W-1:0] P0 = 8'hA6;
    localparam logic [W-1:0] P1 = 8'h3C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcnt = 0; mvalid = 0; movr = 0; mword_m = '0; mword_l = '0;
    endtask

    task automatic model_step();
        bit free, done;
        free = !mvalid || out_ready;
        done = 0;
        movr = 0;
        if (sync) begin
            mcnt = 0;
            if (load) begin
                for (int i = 0; i < L; i++) rx[i][0] = data_in[i];
                mcnt = 1;
            end
        end else if (load) begin
            for (int i = 0; i < L; i++) rx[i][mcnt] = data_in[i];
            mcnt++;
            if (mcnt == W) begin
                mcnt = 0;
                done = 1;
            end
        end
        if (done) begin
            if (free) begin
                for (int i = 0; i < L; i++) begin
                    for (int k = 0; k < W; k++) begin
                        mword_m[i*W + (W-1-k)] = rx[i][k];
                        mword_l[i*W + k]       = rx[i][k];
                    end
                end
                mvalid = 1;
            end else begin
                movr = 1;
            end
        end else if (mvalid && out_ready) begin
            mvalid = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("msb data_out", 32'(dout_m), 32'(mword_m));
            chk("lsb data_out", 32'(dout_l), 32'(mword_l));
            chk("msb out_valid", 32'(v_m), 32'(mvalid));
            chk("lsb out_valid", 32'(v_l), 32'(mvalid));
            chk("msb overrun", 32'(o_m), 32'(movr));
            chk("lsb overrun", 32'(o_l), 32'(movr));
            chk("msb bit_cnt", 32'(bc_m), 32'(mcnt));
            chk("lsb bit_cnt", 32'(bc_l), 32'(mcnt));
        end
    end

    task automatic cycle(input bit ld, input bit sy, input bit [L-1:0] d, input bit rdy);
        load = ld; sync = sy; data_in = d; out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic bit [L-1:0] pat(input int k);
        return {P1[W-1-k], P0[W-1-k]};
    endfunction

    initial begin
        int npulse;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset data_out", 32'(dout_m), 32'h0);
        chk("reset out_valid", 32'(v_m), 32'h0);
        chk("reset bit_cnt", 32'(bc_m), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Basic word, both bit orders from the same serial stream.
        for (int k = 0; k < W; k++) cycle(1, 0, pat(k), 1);
        chk("basic msb word", 32'(dout_m), 32'h3CA6);
        chk("basic lsb word", 32'(dout_l), 32'h3C65);
        chk("basic valid", 32'(v_m), 32'h1);
        cycle(0, 0, '0, 1);
        chk("basic consumed", 32'(v_m), 32'h0);
        chk("basic data held", 32'(dout_m), 32'h3CA6);

        // Reset mid-handshake and mid-word.
        for (int k = 0; k < W + 5; k++) cycle(1, 0, L'($urandom), 0);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 32'(v_m), 32'h0);
        chk("async rst data", 32'(dout_m), 32'h0);
        chk("async rst bit_cnt", 32'(bc_m), 32'h0);
        chk("async rst overrun", 32'(o_m), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W - 1; k++) cycle(1, 0, L'($urandom), 0);
        chk("post rst no word", 32'(v_m), 32'h0);
        chk("post rst bit_cnt", 32'(bc_m), 32'h7);
        cycle(1, 0, L'($urandom), 0);
        chk("post rst word", 32'(v_m), 32'h1);
        cycle(0, 0, '0, 1);

        // Back-pressure: second word dropped.
        for (int k = 0; k < W; k++) cycle(1, 0, pat(k), 0);
        for (int k = 0; k < W; k++) cycle(1, 0, L'($urandom), 0);
        chk("bp overrun", 32'(o_m), 32'h1);
        chk("bp word1 held", 32'(dout_m), 32'h3CA6);
        chk("bp valid held", 32'(v_m), 32'h1);
        cycle(0, 0, '0, 0);
        chk("bp overrun pulse", 32'(o_m), 32'h0);
        cycle(0, 0, '0, 1);
        chk("bp drain", 32'(v_m), 32'h0);

        // Consume and complete on the same edge.
        for (int k = 0; k < W; k++) cycle(1, 0, L'($urandom), 0);
        for (int k = 0; k < W - 1; k++) cycle(1, 0, pat(k), 0);
        cycle(1, 0, pat(W - 1), 1);
        chk("simul valid", 32'(v_m), 32'h1);
        chk("simul no overrun", 32'(o_m), 32'h0);
        chk("simul word2", 32'(dout_m), 32'h3CA6);
        cycle(0, 0, '0, 1);

        // Sync with load, then gapped loads.
        for (int k = 0; k < 3; k++) cycle(1, 0, L'($urandom), 1);
        npulse = 0;
        cycle(1, 1, pat(0), 1);
        chk("sync bit_cnt", 32'(bc_m), 32'h1);
        for (int k = 1; k < W; k++) begin
            cycle(0, 0, L'($urandom), 1);
            if (k == 1) chk("gap bit_cnt hold", 32'(bc_m), 32'h1);
            if (v_m) npulse++;
            cycle(1, 0, pat(k), 1);
            if (v_m) npulse++;
        end
        chk("sync one word", 32'(npulse), 32'h1);
        chk("sync msb word", 32'(dout_m), 32'h3CA6);
        chk("sync lsb word", 32'(dout_l), 32'h3C65);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, L'($urandom), ($urandom % 3) != 0);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
